// File: rtl/flippy_pkg.sv
// Shared types and sizes for the falling-letter game sequencer.
package flippy_pkg;
  localparam int NUM_SLOTS  = 3;
  localparam int YPOS_W     = 5;
  localparam int LETTER_W   = 8;
  localparam int SLOT_IDX_W = $clog2(NUM_SLOTS);

  typedef enum logic {IDLE, FALL} slot_state_t;
  typedef enum logic {RUN, OVER}  game_state_t;

  typedef struct packed {
    slot_state_t         st;
    logic [LETTER_W-1:0] letter;
    logic [YPOS_W-1:0]   ypos;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '{st: IDLE, letter: '0, ypos: '0};

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4; free-running so letters stay unpredictable.
module lfsr8 (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] seed,
  output logic [7:0] q
);
  always_ff @(posedge clock) begin
    if (reset) q <= seed;
    else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end
endmodule

// File: rtl/letter_drop_scheduler.sv
// Game sequencer: spawns, drops and clears three letter slots, keeps score and detects the floor.
module letter_drop_scheduler
  import flippy_pkg::*;
#(
  parameter int         TICK_DIV   = 2500000,
  parameter int         SPAWN_GAP  = 6,
  parameter int         YPOS_FLOOR = 23,
  parameter logic [7:0] LFSR_SEED  = 8'h5A
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [LETTER_W-1:0] guess,
  input  logic                guess_valid,
  output logic [LETTER_W-1:0] letter1,
  output logic [LETTER_W-1:0] letter2,
  output logic [LETTER_W-1:0] letter3,
  output logic [YPOS_W-1:0]   ypos1,
  output logic [YPOS_W-1:0]   ypos2,
  output logic [YPOS_W-1:0]   ypos3,
  output logic [NUM_SLOTS-1:0] active,
  output logic [7:0]          score,
  output logic                hit,
  output logic                miss,
  output logic                game_over
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SPAWN_GAP + 1);
  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]     GAP_C     = SW'(SPAWN_GAP);
  localparam logic [YPOS_W-1:0] FLOOR_Y   = YPOS_W'(YPOS_FLOOR);

  slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
  game_state_t           state, state_d;
  logic [TW-1:0]         tick_cnt, tick_d;
  logic [SW-1:0]         spawn_cnt, spawn_d;
  logic [7:0]            score_d, lfsr;
  logic                  hit_d, miss_d;
  logic                  run, tick, match, free, floor_hit;
  logic [SLOT_IDX_W-1:0] sel, fsel;
  logic [YPOS_W-1:0]     best_y;

  lfsr8 u_lfsr (.clock(clock), .reset(reset), .seed(LFSR_SEED), .q(lfsr));

  always_comb begin
    slots_d   = slots_q;
    state_d   = state;
    tick_d    = tick_cnt;
    spawn_d   = spawn_cnt;
    score_d   = score;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    match     = 1'b0;
    free      = 1'b0;
    floor_hit = 1'b0;
    sel       = '0;
    fsel      = '0;
    best_y    = '0;
    run  = (state == RUN);
    tick = run && enable && (tick_cnt == TICK_LAST);

    // Guess picks the lowest-falling match; strict > keeps the lowest index on ties.
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slots_q[i].st == FALL && slots_q[i].letter == guess &&
          (!match || slots_q[i].ypos > best_y)) begin
        match  = 1'b1;
        sel    = SLOT_IDX_W'(i);
        best_y = slots_q[i].ypos;
      end
    end
    if (run && guess_valid) begin
      if (match) begin
        slots_d[sel] = SLOT_EMPTY;
        score_d      = sat_inc8(score);
        hit_d        = 1'b1;
      end else begin
        miss_d = 1'b1;
      end
    end

    if (run && enable) tick_d = tick ? '0 : tick_cnt + TW'(1);

    // The tick acts on post-guess slots, so a just-cleared slot neither drops nor ends the game.
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++)
        if (slots_d[i].st == FALL && slots_d[i].ypos == FLOOR_Y) floor_hit = 1'b1;
      if (floor_hit) begin
        state_d = OVER;
      end else begin
        for (int i = 0; i < NUM_SLOTS; i++)
          if (slots_d[i].st == FALL) slots_d[i].ypos = slots_d[i].ypos + YPOS_W'(1);
        for (int i = 0; i < NUM_SLOTS; i++)
          if (slots_d[i].st == IDLE && !free) begin
            free = 1'b1;
            fsel = SLOT_IDX_W'(i);
          end
        if (spawn_cnt >= GAP_C) begin
          if (free) begin
            slots_d[fsel] = '{st: FALL, letter: lfsr, ypos: '0};
            spawn_d       = SW'(1);
          end
        end else begin
          spawn_d = spawn_cnt + SW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slots_q   <= '0;
      state     <= RUN;
      tick_cnt  <= '0;
      spawn_cnt <= GAP_C;
      score     <= '0;
      hit       <= 1'b0;
      miss      <= 1'b0;
    end else begin
      slots_q   <= slots_d;
      state     <= state_d;
      tick_cnt  <= tick_d;
      spawn_cnt <= spawn_d;
      score     <= score_d;
      hit       <= hit_d;
      miss      <= miss_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_active
    assign active[i] = (slots_q[i].st == FALL);
  end

  assign letter1   = slots_q[0].letter;
  assign letter2   = slots_q[1].letter;
  assign letter3   = slots_q[2].letter;
  assign ypos1     = slots_q[0].ypos;
  assign ypos2     = slots_q[1].ypos;
  assign ypos3     = slots_q[2].ypos;
  assign game_over = (state == OVER);
endmodule

// File: tb/tb_letter_drop_scheduler.sv
// Directed bench for letter_drop_scheduler with a cycle-level behavioural reference model.
module tb_letter_drop_scheduler;
  localparam int         TICK_DIV   = 4;
  localparam int         SPAWN_GAP  = 2;
  localparam int         YPOS_FLOOR = 23;
  localparam logic [7:0] SEED       = 8'h5A;

  logic       clk = 1'b0, reset = 1'b1, enable = 1'b0, guess_valid = 1'b0;
  logic [7:0] guess = 8'h00;
  logic [7:0] letter1, letter2, letter3, score;
  logic [4:0] ypos1, ypos2, ypos3;
  logic [2:0] active;
  logic       hit, miss, game_over;

  always #5 clk = ~clk;

  letter_drop_scheduler #(
    .TICK_DIV(TICK_DIV), .SPAWN_GAP(SPAWN_GAP), .YPOS_FLOOR(YPOS_FLOOR), .LFSR_SEED(SEED)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable), .guess(guess), .guess_valid(guess_valid),
    .letter1(letter1), .letter2(letter2), .letter3(letter3),
    .ypos1(ypos1), .ypos2(ypos2), .ypos3(ypos3),
    .active(active), .score(score), .hit(hit), .miss(miss), .game_over(game_over)
  );

  int compared = 0, mismatched = 0;
  bit chk_en = 1'b0;

  // Reference model: game rules applied directly to small arrays.
  logic [7:0] m_l[3];
  logic [4:0] m_y[3];
  logic [2:0] m_act;
  logic [7:0] m_score, m_lfsr;
  logic       m_hit, m_miss, m_over;
  int         m_tcnt, m_scnt, best;
  bit         tk;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin m_l[i] = 0; m_y[i] = 0; end
      m_act = 0; m_score = 0; m_hit = 0; m_miss = 0; m_over = 0;
      m_tcnt = 0; m_scnt = SPAWN_GAP; m_lfsr = SEED;
    end else begin
      m_hit = 0; m_miss = 0;
      if (!m_over) begin
        tk = enable && (m_tcnt == TICK_DIV - 1);
        if (guess_valid) begin
          best = -1;
          for (int i = 0; i < 3; i++)
            if (m_act[i] && m_l[i] == guess && (best < 0 || m_y[i] > m_y[best])) best = i;
          if (best >= 0) begin
            m_act[best] = 0; m_l[best] = 0; m_y[best] = 0;
            if (m_score != 8'hFF) m_score = m_score + 1;
            m_hit = 1;
          end else m_miss = 1;
        end
        if (enable) m_tcnt = tk ? 0 : m_tcnt + 1;
        if (tk) begin
          for (int i = 0; i < 3; i++) if (m_act[i] && m_y[i] == YPOS_FLOOR) m_over = 1;
          if (!m_over) begin
            for (int i = 0; i < 3; i++) if (m_act[i]) m_y[i] = m_y[i] + 1;
            if (m_scnt >= SPAWN_GAP) begin
              best = -1;
              for (int i = 0; i < 3; i++) if (!m_act[i] && best < 0) best = i;
              if (best >= 0) begin
                m_act[best] = 1; m_l[best] = m_lfsr; m_y[best] = 0; m_scnt = 1;
              end
            end else m_scnt = m_scnt + 1;
          end
        end
      end
      m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
    end
  end

  logic [52:0] dut_v, exp_v;
  assign dut_v = {letter3, letter2, letter1, ypos3, ypos2, ypos1, active, score, hit, miss, game_over};
  assign exp_v = {m_l[2], m_l[1], m_l[0], m_y[2], m_y[1], m_y[0], m_act, m_score, m_hit, m_miss, m_over};

  always @(negedge clk) begin
    if (chk_en) begin
      compared++;
      if (dut_v !== exp_v) begin
        mismatched++;
        $display("FAIL cycle @%0t: dut=%h model=%h", $time, dut_v, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] g);
    guess = g; guess_valid = 1'b1;
    @(negedge clk);
    guess_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_outputs", {dut_v}, 0);
    reset = 1'b0; enable = 1'b1;

    // First tick on the 4th edge spawns slot 1 with the seed shifted three times.
    repeat (4) @(negedge clk);
    check("t1_active", active, 3'b001);
    check("t1_ypos1", ypos1, 0);
    check("t1_letter1", letter1, 8'hD2);
    check("t1_model_letter1", m_l[0], 8'hD2);

    repeat (8) @(negedge clk);
    check("t2_active", active, 3'b011);
    check("t2_ypos1", ypos1, 2);
    check("t2_ypos2", ypos2, 0);
    check("t2_letter2_nonzero", (letter2 != 0), 1);

    strobe(m_l[1]);
    check("t3_hit", hit, 1);
    check("t3_score", score, 1);
    check("t3_active", active, 3'b001);
    check("t3_letter2", letter2, 0);
    strobe(8'h00);
    check("t3_miss", miss, 1);
    check("t3_miss_score", score, 1);
    @(negedge clk);
    check("t3_miss_pulse", miss, 0);

    // Hold the due spawn until the LFSR cycles back to slot 1's letter.
    n = 0;
    while (!m_act[1] && n < 600) begin
      if (m_tcnt == TICK_DIV - 1 && m_scnt >= SPAWN_GAP) enable = (m_lfsr == m_l[0]);
      else enable = 1'b1;
      @(negedge clk);
      n++;
    end
    enable = 1'b1;
    check("t4_active", active, 3'b011);
    check("t4_letter2", letter2, 8'hD2);
    check("t4_ypos1", ypos1, 4);
    check("t4_ypos2", ypos2, 0);
    strobe(8'hD2);
    check("t4_hit", hit, 1);
    check("t4_active_after", active, 3'b010);
    check("t4_letter1_cleared", letter1, 0);
    check("t4_letter2_kept", letter2, 8'hD2);
    check("t4_score", score, 2);

    n = 0;
    while (game_over !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    check("t5_game_over", game_over, 1);
    check("t5_ypos2_floor", ypos2, 23);
    repeat (10) @(negedge clk);
    check("t5_frozen_ypos2", ypos2, 23);
    strobe(m_l[1]);
    check("t5_no_hit_miss", {hit, miss}, 2'b00);
    check("t5_score_held", score, 2);
    check("t5_sticky", game_over, 1);
    reset = 1'b1;
    @(negedge clk);
    check("t5_reset_outputs", {dut_v}, 0);
    reset = 1'b0;

    // Clear slot 1 on the very tick that would otherwise end the game.
    n = 0;
    while (!(m_tcnt == TICK_DIV - 1 && m_act[0] && m_y[0] == 23) && n < 300) begin
      @(negedge clk); n++;
    end
    check("t6_reached_floor", ypos1, 23);
    strobe(m_l[0]);
    check("t6_hit", hit, 1);
    check("t6_no_game_over", game_over, 0);
    check("t6_active_respawn", active, 3'b111);
    check("t6_ypos", {ypos3, ypos2, ypos1}, {5'd20, 5'd22, 5'd0});
    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_paused_ypos", {ypos3, ypos2, ypos1}, {5'd20, 5'd22, 5'd0});
    check("t6_paused_over", game_over, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
